// File: rtl/mmc1_serial_regfile_pkg.sv
// Shared constants and types for the MMC1 serial-load register file.
package mmc1_pkg;

    localparam int MMC1_DATA_BIT  = 0;
    localparam int MMC1_RESET_BIT = 7;
    localparam int MMC1_SHIFT_W   = 5;

    localparam logic [MMC1_SHIFT_W-1:0] MMC1_CTRL_RESET_VAL = 5'h0C;

    typedef logic [MMC1_SHIFT_W-1:0] mmc1_shift_t;

    // Bit offset of register idx inside the flattened register file.
    function automatic int unsigned mmc1_reg_offset(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mmc1_shift_loader.sv
// Serial load front end: LSB-first shift register, bit counter, reset-write
// decode and the optional consecutive-write filter
// (macro MMC1_CONSEC_WRITE_FILTER_EN).
module mmc1_shift_loader
    import mmc1_pkg::*;
#(
    parameter int SHIFT_W = MMC1_SHIFT_W
) (
    input  logic               ck,
    input  logic               res,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               commit,
    output logic [SHIFT_W-1:0] commit_data,
    output logic               reset_wr,
    output logic [2:0]         shift_cnt
);

    localparam logic [2:0] LAST_CNT = 3'(SHIFT_W - 1);

    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               accept;
    logic               unused_wr_data;

    // Only the reset bit and the data bit carry meaning.
    assign unused_wr_data = ^wr_data;

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
    logic prev_wr_q;

    // Remember last cycle's strobe so the second write of a RMW pair is dropped.
    always_ff @(posedge ck or posedge res) begin
        if (res) prev_wr_q <= 1'b0;
        else     prev_wr_q <= wr_en;
    end

    assign accept = wr_en & ~prev_wr_q;
`else
    assign accept = wr_en;
`endif

    // Decode the accepted write into shift, commit or reset-write.
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        commit      = 1'b0;
        reset_wr    = 1'b0;
        commit_data = {wr_data[MMC1_DATA_BIT], shift_q[SHIFT_W-1:1]};
        if (accept) begin
            if (wr_data[MMC1_RESET_BIT]) begin
                reset_wr = 1'b1;
                shift_d  = '0;
                cnt_d    = '0;
            end else if (cnt_q == LAST_CNT) begin
                commit  = 1'b1;
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = commit_data;
                cnt_d   = cnt_q + 3'd1;
            end
        end
    end

    // Shift register and bit counter.
    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign shift_cnt = cnt_q;

endmodule

// File: rtl/mmc1_serial_regfile.sv
// MMC1 serial-load register file: register bank, commit pulse and index.
// Optional consecutive-write filter lives in the loader, enabled by
// defining MMC1_CONSEC_WRITE_FILTER_EN.
module mmc1_serial_regfile
    import mmc1_pkg::*;
#(
    parameter int                 SHIFT_W        = 5,
    parameter int                 NUM_REGS       = 4,
    parameter int                 SEL_W          = 2,
    parameter logic [SHIFT_W-1:0] CTRL_RESET_VAL = SHIFT_W'(MMC1_CTRL_RESET_VAL)
) (
    input  logic                         ck,
    input  logic                         res,
    input  logic                         wr_en,
    input  logic [SEL_W-1:0]             wr_sel,
    input  logic [7:0]                   wr_data,
    output logic [NUM_REGS*SHIFT_W-1:0]  reg_q,
    output logic                         load_done,
    output logic [SEL_W-1:0]             load_idx,
    output logic [2:0]                   shift_cnt
);

    localparam logic [NUM_REGS-1:0][SHIFT_W-1:0] REGS_RST = (NUM_REGS*SHIFT_W)'(CTRL_RESET_VAL);

    logic [NUM_REGS-1:0][SHIFT_W-1:0] regs_q, regs_d;
    logic                             load_done_q, load_done_d;
    logic [SEL_W-1:0]                 load_idx_q, load_idx_d;
    logic                             commit;
    logic                             reset_wr;
    logic [SHIFT_W-1:0]               commit_data;

    mmc1_shift_loader #(
        .SHIFT_W (SHIFT_W)
    ) u_loader (
        .ck          (ck),
        .res         (res),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .commit      (commit),
        .commit_data (commit_data),
        .reset_wr    (reset_wr),
        .shift_cnt   (shift_cnt)
    );

    // Apply a commit to the selected register or OR the reset value into register 0.
    always_comb begin
        regs_d      = regs_q;
        load_done_d = 1'b0;
        load_idx_d  = load_idx_q;
        if (reset_wr) begin
            regs_d[0] = regs_q[0] | CTRL_RESET_VAL;
        end
        if (commit) begin
            regs_d[wr_sel] = commit_data;
            load_done_d    = 1'b1;
            load_idx_d     = wr_sel;
        end
    end

    // Register bank and commit status flops.
    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            regs_q      <= REGS_RST;
            load_done_q <= 1'b0;
            load_idx_q  <= '0;
        end else begin
            regs_q      <= regs_d;
            load_done_q <= load_done_d;
            load_idx_q  <= load_idx_d;
        end
    end

    assign reg_q     = regs_q;
    assign load_done = load_done_q;
    assign load_idx  = load_idx_q;

endmodule

// File: tb/tb_mmc1_serial_regfile.sv
// Scoreboard bench for mmc1_serial_regfile: default instance (5x4) and a
// wide instance (8x8). Expected commits are queued by the stimulus; a
// monitor pops them whenever load_done is seen.
module tb_mmc1_serial_regfile;
    import mmc1_pkg::*;

    logic ck = 1'b0;
    logic clk_run = 1'b1;
    logic res;

    always #5 if (clk_run) ck = ~ck;

    logic        wr_en_a, load_done_a;
    logic [1:0]  wr_sel_a, load_idx_a;
    logic [7:0]  wr_data_a;
    logic [19:0] reg_q_a;
    logic [2:0]  shift_cnt_a;

    logic        wr_en_b, load_done_b;
    logic [2:0]  wr_sel_b, load_idx_b;
    logic [7:0]  wr_data_b;
    logic [63:0] reg_q_b;
    logic [2:0]  shift_cnt_b;

    mmc1_serial_regfile dut_a (
        .ck        (ck),
        .res       (res),
        .wr_en     (wr_en_a),
        .wr_sel    (wr_sel_a),
        .wr_data   (wr_data_a),
        .reg_q     (reg_q_a),
        .load_done (load_done_a),
        .load_idx  (load_idx_a),
        .shift_cnt (shift_cnt_a)
    );

    mmc1_serial_regfile #(
        .SHIFT_W        (8),
        .NUM_REGS       (8),
        .SEL_W          (3),
        .CTRL_RESET_VAL (8'h0C)
    ) dut_b (
        .ck        (ck),
        .res       (res),
        .wr_en     (wr_en_b),
        .wr_sel    (wr_sel_b),
        .wr_data   (wr_data_b),
        .reg_q     (reg_q_b),
        .load_done (load_done_b),
        .load_idx  (load_idx_b),
        .shift_cnt (shift_cnt_b)
    );

    typedef struct {
        logic [2:0] idx;
        logic [7:0] val;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] slice_a(input int unsigned i);
        return 8'(reg_q_a >> mmc1_reg_offset(i, 5)) & 8'h1F;
    endfunction

    function automatic logic [7:0] slice_b(input int unsigned i);
        return 8'(reg_q_b >> mmc1_reg_offset(i, 8));
    endfunction

    // Monitor: every load_done must match the oldest queued expectation.
    always @(negedge ck) begin
        exp_t e;
        if (load_done_a) begin
            if (q_a.size() == 0) begin
                n_checks++;
                $display("FAIL a_unexpected_load_done: got load_idx %0d with no commit queued", load_idx_a);
            end else begin
                e = q_a.pop_front();
                check("a_load_idx", 64'(load_idx_a), 64'(e.idx[1:0]));
                check("a_commit_val", 64'(slice_a(e.idx)), 64'(e.val));
            end
        end
        if (load_done_b) begin
            if (q_b.size() == 0) begin
                n_checks++;
                $display("FAIL b_unexpected_load_done: got load_idx %0d with no commit queued", load_idx_b);
            end else begin
                e = q_b.pop_front();
                check("b_load_idx", 64'(load_idx_b), 64'(e.idx));
                check("b_commit_val", 64'(slice_b(e.idx)), 64'(e.val));
            end
        end
    end

    task automatic wr_a(input logic [1:0] sel, input logic [7:0] d);
        @(posedge ck); #1;
        wr_en_a = 1'b1; wr_sel_a = sel; wr_data_a = d;
        @(posedge ck); #1;
        wr_en_a = 1'b0; wr_data_a = 8'h00;
    endtask

    task automatic wr_b(input logic [2:0] sel, input logic [7:0] d);
        @(posedge ck); #1;
        wr_en_b = 1'b1; wr_sel_b = sel; wr_data_b = d;
        @(posedge ck); #1;
        wr_en_b = 1'b0; wr_data_b = 8'h00;
    endtask

    task automatic load_a(input logic [1:0] sel, input logic [4:0] val);
        q_a.push_back('{idx: {1'b0, sel}, val: {3'b000, val}});
        for (int i = 0; i < 5; i++) wr_a(sel, {7'b0, val[i]});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    initial begin
        res = 1'b1;
        wr_en_a = 1'b0; wr_sel_a = '0; wr_data_a = '0;
        wr_en_b = 1'b0; wr_sel_b = '0; wr_data_b = '0;
        #12 res = 1'b0;
        idle(2);

        // Serial load 1,0,1,1,0 into register 1.
        load_a(2'd1, 5'b01101);
        idle(2);
        check("a_shift_cnt_after_load", 64'(shift_cnt_a), 64'd0);
        check("a_reg1", 64'(slice_a(1)), 64'h0D);

        // Reset write in the middle of a partial load.
        load_a(2'd0, 5'b10001);
        wr_a(2'd0, 8'h01);
        wr_a(2'd0, 8'h01);
        wr_a(2'd0, 8'h01);
        check("a_shift_cnt_partial", 64'(shift_cnt_a), 64'd3);
        wr_a(2'd3, 8'h81);
        check("a_shift_cnt_after_rstwr", 64'(shift_cnt_a), 64'd0);
        check("a_reg0_or_reset", 64'(slice_a(0)), 64'h1D);
        load_a(2'd3, 5'b11111);
        idle(2);
        check("a_reg0_kept", 64'(slice_a(0)), 64'h1D);
        check("a_reg3", 64'(slice_a(3)), 64'h1F);

        // Back-to-back write pair followed by spaced writes.
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
        q_a.push_back('{idx: 3'd2, val: 8'h01});
`else
        q_a.push_back('{idx: 3'd2, val: 8'h03});
`endif
        @(posedge ck); #1;
        wr_en_a = 1'b1; wr_sel_a = 2'd2; wr_data_a = 8'h01;
        @(posedge ck); #1;
        @(posedge ck); #1;
        wr_en_a = 1'b0; wr_data_a = 8'h00;
        for (int i = 0; i < 4; i++) wr_a(2'd2, 8'h00);
        idle(2);
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
        check("a_filter_reg2", 64'(slice_a(2)), 64'h01);
        check("a_filter_shift_cnt", 64'(shift_cnt_a), 64'd0);
`else
        check("a_nofilter_reg2", 64'(slice_a(2)), 64'h03);
        check("a_nofilter_shift_cnt", 64'(shift_cnt_a), 64'd1);
`endif

        // Wide instance: 8'hA5 into register 7, LSB first.
        q_b.push_back('{idx: 3'd7, val: 8'hA5});
        for (int i = 0; i < 8; i++) wr_b(3'd7, {7'b0, ((8'hA5 >> i) & 8'h01) != 8'h00});
        idle(2);
        check("b_reg7", 64'(reg_q_b[63:56]), 64'hA5);
        for (int i = 0; i < 4; i++) wr_b(3'd7, 8'h01);
        check("b_shift_cnt_partial", 64'(shift_cnt_b), 64'd4);

        // Asynchronous reset with the clock stopped.
        clk_run = 1'b0;
        #10 res = 1'b1;
        #1;
        check("a_reset_reg_q", 64'(reg_q_a), 64'h0000C);
        check("a_reset_shift_cnt", 64'(shift_cnt_a), 64'd0);
        check("a_reset_load_done", 64'(load_done_a), 64'd0);
        check("a_reset_load_idx", 64'(load_idx_a), 64'd0);
        check("b_reset_shift_cnt", 64'(shift_cnt_b), 64'd0);
        check("b_reset_reg7", 64'(reg_q_b[63:56]), 64'h00);
        check("b_reset_reg_q", reg_q_b, 64'h0C);
        #4 res = 1'b0;
        clk_run = 1'b1;
        idle(2);

        // Load after reset works from a clean shift register.
        load_a(2'd2, 5'b10110);
        idle(4);
        check("a_reg2_after_reset", 64'(slice_a(2)), 64'h16);
        check("a_queue_drained", 64'(q_a.size()), 64'd0);
        check("b_queue_drained", 64'(q_b.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
